// File: rtl/requant_mbqm_vec.sv
// Multi-lane TFLite MultiplyByQuantizedMultiplier requantizer with a 5-stage valid/ready pipeline.
// Optional macro REQUANT_PER_CHANNEL_EN: per-lane multiplier/shift; otherwise lane 0's apply to all lanes.
module requant_mbqm_vec #(
   parameter int LANES = 4,
   parameter int OUT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*32-1:0]      in_acc,
   input  logic [LANES*32-1:0]      in_mult,
   input  logic [LANES*6-1:0]       in_shift,
   input  logic [31:0]              out_zp,
   input  logic [OUT_W-1:0]         act_min,
   input  logic [OUT_W-1:0]         act_max,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*OUT_W-1:0]   out_data
);

`ifdef REQUANT_PER_CHANNEL_EN
   localparam int ML = LANES;
`else
   localparam int ML = 1;
`endif

   localparam logic signed [31:0] I32_MAX   = 32'sh7FFFFFFF;
   localparam logic signed [31:0] I32_MIN   = 32'sh80000000;
   localparam logic signed [63:0] L_MAX     = 64'sd2147483647;
   localparam logic signed [63:0] L_MIN     = -64'sd2147483648;
   localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
   localparam logic signed [63:0] NUDGE_NEG = 64'sd1 - 64'sd1073741824;
   localparam logic signed [63:0] TRUNC_ADJ = 64'sd2147483647;

   function automatic int unsigned pm(input int unsigned i);
      return (ML == 1) ? 0 : i;
   endfunction

   generate
      if (ML < LANES) begin : g_shared
         logic unused_upper;
         assign unused_upper = ^{in_mult[LANES*32-1:32], in_shift[LANES*6-1:6]};
      end
   endgenerate

   logic en;
   logic v1, v2, v3, v4;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Stage registers
   logic signed [31:0]      s1_a   [LANES];
   logic                    s1_ovf [LANES];
   logic signed [31:0]      s1_m   [ML];
   logic [4:0]              s1_r   [ML];
   logic signed [31:0]      s1_zp;
   logic signed [OUT_W-1:0] s1_min, s1_max;

   logic signed [63:0]      s2_p   [LANES];
   logic                    s2_ovf [LANES];
   logic [4:0]              s2_r   [ML];
   logic signed [31:0]      s2_zp;
   logic signed [OUT_W-1:0] s2_min, s2_max;

   logic signed [31:0]      s3_h   [LANES];
   logic [4:0]              s3_r   [ML];
   logic signed [31:0]      s3_zp;
   logic signed [OUT_W-1:0] s3_min, s3_max;

   logic signed [31:0]      s4_sh  [LANES];
   logic                    s4_inc [LANES];
   logic signed [31:0]      s4_zp;
   logic signed [OUT_W-1:0] s4_min, s4_max;

   // Combinational stage logic
   logic signed [5:0]       c_sh    [ML];
   logic [4:0]              c_left  [ML];
   logic [4:0]              c_right [ML];
   logic signed [63:0]      c_t     [LANES];
   logic signed [31:0]      c_a     [LANES];
   logic                    c_ovf   [LANES];
   logic signed [63:0]      c_q     [LANES];
   logic signed [63:0]      c_qt    [LANES];
   logic signed [31:0]      c_h     [LANES];
   logic [31:0]             c_mask  [LANES];
   logic [31:0]             c_rem   [LANES];
   logic [31:0]             c_thr   [LANES];
   logic                    c_inc   [LANES];
   logic signed [31:0]      c_shr   [LANES];
   logic signed [31:0]      c_r     [LANES];
   logic signed [32:0]      c_z33   [LANES];
   logic signed [31:0]      c_z     [LANES];
   logic signed [31:0]      c_y     [LANES];
   logic signed [31:0]      c_lo, c_hi;
   logic [LANES*OUT_W-1:0]  c_out;

   always_comb begin
      for (int unsigned m = 0; m < ML; m++) begin
         c_sh[m]    = signed'(in_shift[6*m +: 6]);
         c_left[m]  = '0;
         c_right[m] = '0;
         if (c_sh[m][5]) begin
            c_right[m] = (in_shift[6*m +: 6] == 6'b100000) ? 5'd31 : 5'(-c_sh[m]);
         end else begin
            c_left[m] = c_sh[m][4:0];
         end
      end
      for (int unsigned i = 0; i < LANES; i++) begin
         c_t[i] = 64'(signed'(in_acc[32*i +: 32])) <<< c_left[pm(i)];
         if (c_t[i] > L_MAX)
            c_a[i] = I32_MAX;
         else if (c_t[i] < L_MIN)
            c_a[i] = I32_MIN;
         else
            c_a[i] = 32'(c_t[i]);
         c_ovf[i] = (c_a[i] == I32_MIN) && (in_mult[32*pm(i) +: 32] == I32_MIN);
      end
   end

   // Rounding-doubling high multiply: nudge, then divide by 2^31 truncating toward zero
   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         c_q[i]  = s2_p[i] + (s2_p[i][63] ? NUDGE_NEG : NUDGE_POS);
         c_qt[i] = c_q[i][63] ? (c_q[i] + TRUNC_ADJ) : c_q[i];
         c_h[i]  = s2_ovf[i] ? I32_MAX : 32'(c_qt[i] >>> 31);
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         c_mask[i] = (32'd1 << s3_r[pm(i)]) - 32'd1;
         c_rem[i]  = s3_h[i] & c_mask[i];
         c_thr[i]  = (c_mask[i] >> 1) + {31'd0, s3_h[i][31]};
         c_inc[i]  = c_rem[i] > c_thr[i];
         c_shr[i]  = s3_h[i] >>> s3_r[pm(i)];
      end
   end

   // Zero-point add saturates to int32; clamp applies act_max last so an inverted range yields act_max
   always_comb begin
      c_lo  = 32'(s4_min);
      c_hi  = 32'(s4_max);
      c_out = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         c_r[i]   = s4_sh[i] + signed'({31'd0, s4_inc[i]});
         c_z33[i] = 33'(c_r[i]) + 33'(s4_zp);
         if (c_z33[i][32] != c_z33[i][31])
            c_z[i] = c_z33[i][32] ? I32_MIN : I32_MAX;
         else
            c_z[i] = c_z33[i][31:0];
         c_y[i] = (c_z[i] < c_lo) ? c_lo : c_z[i];
         if (c_y[i] > c_hi)
            c_y[i] = c_hi;
         c_out[OUT_W*i +: OUT_W] = OUT_W'(c_y[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         v4        <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (en) begin
         v1        <= in_valid;
         v2        <= v1;
         v3        <= v2;
         v4        <= v3;
         out_valid <= v4;
         if (v4)
            out_data <= c_out;
      end
   end

   always_ff @(posedge clk) begin
      if (en && in_valid) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            s1_a[i]   <= c_a[i];
            s1_ovf[i] <= c_ovf[i];
         end
         for (int unsigned m = 0; m < ML; m++) begin
            s1_m[m] <= signed'(in_mult[32*m +: 32]);
            s1_r[m] <= c_right[m];
         end
         s1_zp  <= signed'(out_zp);
         s1_min <= signed'(act_min);
         s1_max <= signed'(act_max);
      end
      if (en && v1) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            s2_p[i]   <= 64'(s1_a[i]) * 64'(s1_m[pm(i)]);
            s2_ovf[i] <= s1_ovf[i];
         end
         for (int unsigned m = 0; m < ML; m++)
            s2_r[m] <= s1_r[m];
         s2_zp  <= s1_zp;
         s2_min <= s1_min;
         s2_max <= s1_max;
      end
      if (en && v2) begin
         for (int unsigned i = 0; i < LANES; i++)
            s3_h[i] <= c_h[i];
         for (int unsigned m = 0; m < ML; m++)
            s3_r[m] <= s2_r[m];
         s3_zp  <= s2_zp;
         s3_min <= s2_min;
         s3_max <= s2_max;
      end
      if (en && v3) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            s4_sh[i]  <= c_shr[i];
            s4_inc[i] <= c_inc[i];
         end
         s4_zp  <= s3_zp;
         s4_min <= s3_min;
         s4_max <= s3_max;
      end
   end

endmodule

// File: tb/tb_requant_mbqm_vec.sv
// Directed self-checking bench for requant_mbqm_vec (8-bit and 16-bit output instances).
module tb_requant_mbqm_vec;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         in_valid, in_ready, out_valid, out_ready;
   logic [127:0] in_acc, in_mult;
   logic [23:0]  in_shift;
   logic [31:0]  out_zp;
   logic [7:0]   act_min, act_max;
   logic [31:0]  out_data;

   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [127:0] b_acc, b_mult;
   logic [23:0]  b_shift;
   logic [31:0]  b_zp;
   logic [15:0]  b_min, b_max;
   logic [63:0]  b_data;

   int tests = 0;
   int fails = 0;

   requant_mbqm_vec #(.LANES(4), .OUT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_acc(in_acc), .in_mult(in_mult), .in_shift(in_shift), .out_zp(out_zp),
      .act_min(act_min), .act_max(act_max), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   requant_mbqm_vec #(.LANES(4), .OUT_W(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_acc(b_acc), .in_mult(b_mult), .in_shift(b_shift), .out_zp(b_zp),
      .act_min(b_min), .act_max(b_max), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_data)
   );

   task automatic drive(input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                        input logic [31:0] x3, input logic [31:0] m, input logic [5:0] s,
                        input logic [31:0] zp, input logic [7:0] amin, input logic [7:0] amax);
      in_acc    = {x3, x2, x1, x0};
      in_mult   = {4{m}};
      in_shift  = {4{s}};
      out_zp    = zp;
      act_min   = amin;
      act_max   = amax;
      in_valid  = 1'b1;
      out_ready = 1'b1;
   endtask

   task automatic run_beat(output logic [31:0] data, output int lat);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin
         @(posedge clk);
         #1 lat++;
      end
      data = out_data;
   endtask

   task automatic run_beat16(output logic [63:0] data, output int lat);
      b_in_valid  = 1'b1;
      b_out_ready = 1'b1;
      @(posedge clk);
      #1 b_in_valid = 1'b0;
      lat = 1;
      while (!b_out_valid && lat < 12) begin
         @(posedge clk);
         #1 lat++;
      end
      data = b_data;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      tests++;
      if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      tests++;
      if (b_out_valid !== 1'b0) begin fails++; $display("FAIL reset_w16_out_valid: got %b expected 0", b_out_valid); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] d;
      int lat;
      @(negedge clk);
      drive(32'd100, 32'd20, -32'sd40, 32'd254, 32'h40000000, 6'd0, 32'd0, 8'h80, 8'h7F);
      run_beat(d, lat);
      tests++;
      if (lat !== 5) begin fails++; $display("FAIL basic_latency: got %0d expected 5", lat); end
      tests++;
      if (d !== 32'h7FEC0A32) begin fails++; $display("FAIL basic_data: got %h expected 7fec0a32", d); end
   endtask

   task automatic test_rounding();
      logic [31:0] d;
      int lat;
      @(negedge clk);
      drive(32'd1000, -32'sd1000, 32'd1000, -32'sd1000, 32'h40000000, 6'h3D, 32'd0, 8'h80, 8'h7F);
      run_beat(d, lat);
      tests++;
      if (d !== 32'hC13FC13F) begin fails++; $display("FAIL round_tie_shift_m3: got %h expected c13fc13f", d); end
      @(negedge clk);
      drive(32'd3, -32'sd3, 32'd3, -32'sd3, 32'h40000000, 6'd2, 32'd0, 8'h80, 8'h7F);
      run_beat(d, lat);
      tests++;
      if (d !== 32'hFA06FA06) begin fails++; $display("FAIL left_shift_p2: got %h expected fa06fa06", d); end
   endtask

   task automatic test_saturation();
      logic [31:0] d;
      int lat;
      @(negedge clk);
      drive(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 6'd0,
            32'd0, 8'h80, 8'h7F);
      run_beat(d, lat);
      tests++;
      if (d !== 32'h7F7F7F7F) begin fails++; $display("FAIL srdhm_min_min: got %h expected 7f7f7f7f", d); end
      @(negedge clk);
      drive(32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h40000000, 6'd4,
            32'd0, 8'h80, 8'h7F);
      run_beat(d, lat);
      tests++;
      if (d !== 32'h807F807F) begin fails++; $display("FAIL left_shift_sat: got %h expected 807f807f", d); end
   endtask

   task automatic test_zero_point_clamp();
      logic [31:0] d;
      int lat;
      @(negedge clk);
      drive(32'd100, 32'd100, 32'd100, 32'd100, 32'h40000000, 6'd0, -32'sd128, 8'h80, 8'h7F);
      run_beat(d, lat);
      tests++;
      if (d !== 32'hB2B2B2B2) begin fails++; $display("FAIL zp_minus128: got %h expected b2b2b2b2", d); end
      @(negedge clk);
      drive(32'd100, 32'd100, 32'd100, 32'd100, 32'h40000000, 6'd0, -32'sd128, 8'h80, 8'h9C);
      run_beat(d, lat);
      tests++;
      if (d !== 32'h9C9C9C9C) begin fails++; $display("FAIL clamp_max_m100: got %h expected 9c9c9c9c", d); end
      @(negedge clk);
      drive(32'd100, 32'd100, 32'd100, 32'd100, 32'h40000000, 6'd0, 32'd0, 8'd10, 8'd5);
      run_beat(d, lat);
      tests++;
      if (d !== 32'h05050505) begin fails++; $display("FAIL clamp_inverted: got %h expected 05050505", d); end
      @(negedge clk);
      drive(32'd100, 32'd100, 32'd100, 32'd100, 32'h40000000, 6'd0, 32'h7FFFFFF0, 8'h80, 8'h7F);
      run_beat(d, lat);
      tests++;
      if (d !== 32'h7F7F7F7F) begin fails++; $display("FAIL zp_saturate: got %h expected 7f7f7f7f", d); end
   endtask

   task automatic test_out_w16();
      logic [63:0] d;
      int lat;
      @(negedge clk);
      b_acc   = {32'd1000, 32'd1000, 32'd1000, 32'h00100000};
      b_mult  = {4{32'h7FFFFFFF}};
      b_shift = '0;
      b_zp    = '0;
      b_min   = 16'h8000;
      b_max   = 16'h7FFF;
      run_beat16(d, lat);
      tests++;
      if (lat !== 5) begin fails++; $display("FAIL w16_latency: got %0d expected 5", lat); end
      tests++;
      if (d !== 64'h03E8_03E8_03E8_7FFF) begin fails++; $display("FAIL w16_data: got %h expected 03e803e803e87fff", d); end
   endtask

   task automatic test_per_channel();
      logic [63:0] d;
      logic [63:0] exp_d;
      int lat;
`ifdef REQUANT_PER_CHANNEL_EN
      exp_d = 64'h0032_0064_00C8_0190;
`else
      exp_d = 64'h0190_0190_0190_0190;
`endif
      @(negedge clk);
      b_acc   = {4{32'd800}};
      b_mult  = {4{32'h40000000}};
      b_shift = {6'h3D, 6'h3E, 6'h3F, 6'h00};
      b_zp    = '0;
      b_min   = 16'h8000;
      b_max   = 16'h7FFF;
      run_beat16(d, lat);
      tests++;
      if (d !== exp_d) begin fails++; $display("FAIL per_channel: got %h expected %h", d, exp_d); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_q[$];
      int sent = 0;
      int got = 0;
      int cyc = 0;
      int stalls = 0;
      while (got < 8 && cyc < 100) begin
         @(negedge clk);
         out_ready = !(cyc >= 8 && cyc < 11);
         if (sent < 8) begin
            drive(32'(20*sent+2), 32'(20*sent+4), 32'(20*sent+6), 32'(20*sent+8),
                  32'h40000000, 6'd0, 32'd0, 8'h80, 8'h7F);
            out_ready = !(cyc >= 8 && cyc < 11);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && !out_ready) begin
            stalls++;
            tests++;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
            tests++;
            if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
               fails++; $display("FAIL stall_hold: got %h expected %h", out_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
            end
         end
         if (out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
               fails++; $display("FAIL stream_data: got %h expected %h", out_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({8'(10*sent+4), 8'(10*sent+3), 8'(10*sent+2), 8'(10*sent+1)});
            sent++;
         end
         cyc++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tests++;
      if (got !== 8) begin fails++; $display("FAIL stream_count: got %0d expected 8", got); end
      tests++;
      if (stalls !== 3) begin fails++; $display("FAIL stall_cycles: got %0d expected 3", stalls); end
   endtask

   task automatic test_reset_midstream();
      int seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(32'd100, 32'd100, 32'd100, 32'd100, 32'h40000000, 6'd0, 32'd0, 8'h80, 8'h7F);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
      @(negedge clk);
      rst = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1 if (out_valid) seen++;
      end
      tests++;
      if (seen !== 0) begin fails++; $display("FAIL midreset_stale: got %0d outputs expected 0", seen); end
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1;
      in_acc = '0; in_mult = '0; in_shift = '0; out_zp = '0; act_min = '0; act_max = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b1;
      b_acc = '0; b_mult = '0; b_shift = '0; b_zp = '0; b_min = '0; b_max = '0;
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_zero_point_clamp();
      test_out_w16();
      test_per_channel();
      test_back_to_back();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/requant_mbqm_vec.md
# requant_mbqm_vec

Multi-lane, parametrised requantizer that applies TFLite-exact `MultiplyByQuantizedMultiplier` to LANES int32 accumulators per beat. It then adds the output zero point and clamps to the activation range, producing OUT_W-bit signed results. It sits between the MAC/accumulator array and the output writeback in the NPU datapath. It replaces the single-lane, fixed-int8, no-backpressure requant stage with a valid/ready pipeline.

## Interface
Parameters:
- LANES, 4: lanes processed per beat.
- OUT_W, 8: signed output width (2..32).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_acc  in  LANES*32  signed int32 accumulators; lane i = [32i+31:32i].
- in_mult  in  LANES*32  signed quantized multipliers, per lane.
- in_shift  in  LANES*6  signed shifts, per lane, range -31..+31.
- out_zp  in  32  signed output zero point; quasi-static, sampled with each accepted beat.
- act_min  in  OUT_W  signed lower clamp; sampled with each accepted beat.
- act_max  in  OUT_W  signed upper clamp; sampled with each accepted beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  LANES*OUT_W  signed results; lane i = [OUT_W*i+OUT_W-1:OUT_W*i].

## Operation
The following steps apply per lane. All arithmetic is signed.

- left = max(shift,0), right = min(max(-shift,0),31).
- Left shift: a = x<<left, computed in 64 bits and saturated to int32.
- SRDHM:
  - If a == b == INT32_MIN, h = 0x7FFFFFFF.
  - Otherwise p = a*b (64-bit), nudge = p>=0 ? 2^30 : 1-2^30, h = (p+nudge)/2^31 truncated toward zero, low 32 bits.
- RDBPOT:
  - mask = 2^right-1, rem = h & mask.
  - thr = (mask>>1) + (h<0).
  - r = (h>>>right) + (rem>thr).
- Zero point: z = r + out_zp, saturated to int32.
- Clamp: y = min(max(z, act_min), act_max), sign-extended comparisons. If act_min > act_max, the result is act_max.
- out_data lane = y[OUT_W-1:0].
- No intermediate stage may saturate to a hardcoded ±127/-128. The only saturation points are those listed above.

## Timing
- 5-stage pipeline:
  - S1: register inputs, shift decode, left shift/saturate, overflow flag.
  - S2: 32x32 multiply.
  - S3: nudge add, high word, overflow select.
  - S4: rem/thr, arithmetic shift.
  - S5: round increment, zero point, clamp.
- Latency: accepted beat appears on out_data exactly 5 cycles later when there is no stall.
- Throughput: 1 beat/cycle.
- Global stall enable: en = !out_valid || out_ready; in_ready = en (combinational).
  - When en=0, all stage registers and valid bits hold.
  - Data already in flight must not be dropped or duplicated.
- Valid bits advance only on en. Data registers load only when en and their stage input is valid.
- out_valid/out_data must stay stable while out_valid && !out_ready.
- Order is preserved. Simultaneous accept-in and accept-out in the same cycle is legal.
- Reset (rst=0 at posedge): all stage valids=0, out_valid=0, out_data=0, in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight beats. No output is produced for them.
- in_acc/in_mult/in_shift/out_zp/act_* are ignored when in_valid=0.

## Configuration
- REQUANT_PER_CHANNEL_EN defined: each lane uses its own in_mult/in_shift slice.
- Undefined: lane 0's in_mult/in_shift apply to all lanes. Upper slices are ignored and their pipeline registers are not instantiated. Port widths are unchanged.

## Test plan
- x=100, mult=0x40000000, shift=0, zp=0, act=[-128,127] -> 50 after exactly 5 cycles.
- x=1000 / x=-1000, mult=0x40000000, shift=-3 -> 63 / -63 (tie rounds away from zero); x=3, shift=+2 -> 6.
- x=mult=0x80000000, shift=0 -> h=0x7FFFFFFF -> clamp 127. Separately, x=0x7FFFFFFF, shift=+4 -> left-shift saturation, result 127.
- x=100, mult=0x40000000, shift=0, zp=-128 -> -78; same with act_max=-100 -> -100; OUT_W=16, zp=0, x=2^20, mult=0x7FFFFFFF -> 32767.
- Stream 8 back-to-back beats, drop out_ready for 3 cycles mid-stream -> in_ready low during stall, out_data held stable, all 8 results emitted in order with none lost. Assert rst mid-stream -> out_valid=0 next cycle, no stale outputs.
- LANES=4, per-lane shifts {0,-1,-2,-3}, x=800, mult=0x40000000 -> with REQUANT_PER_CHANNEL_EN {400,200,100,50}; without the macro {400,400,400,400}.
